// File: rtl/dh_status_tx.sv
// Byte-serial transmitter for the key-exchange status word: detects a zero-to-nonzero
// status edge and streams the captured word MSB byte first, optionally followed by a terminator.
module dh_status_tx #(
  parameter int         WORD_BYTES = 6,
  parameter bit         TERM_EN    = 1'b1,
  parameter logic [7:0] TERM_BYTE  = 8'h0A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] status_in,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    sent_pulse,
  output logic [7:0]              drop_cnt
);

  // state | meaning
  // IDLE  | waiting for a zero-to-nonzero edge on status_in
  // SEND  | presenting captured word bytes, MSB first
  // TERM  | presenting the terminator byte
  // DONE  | one-cycle sent_pulse, then back to IDLE

  localparam int WW    = 8 * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic             prev_zero;
  logic [WW-1:0]    shreg;
  logic [IDX_W-1:0] idx;
  logic             trigger;
  logic             handshake;

  assign trigger   = prev_zero & (status_in != '0);
  assign handshake = tx_valid & tx_ready;

  // prev_zero starts at 1 so a word already present at reset release is sent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_zero <= 1'b1;
    end else begin
      prev_zero <= (status_in == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'd0;
    end else if (trigger && (state != IDLE) && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // shreg holds the not-yet-presented bytes left-aligned; tx_data is loaded from its top byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      sent_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sent_pulse <= 1'b0;
          if (trigger) begin
            state    <= SEND;
            tx_data  <= status_in[WW-1 -: 8];
            shreg    <= status_in << 8;
            idx      <= '0;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              if (TERM_EN) begin
                state   <= TERM;
                tx_data <= TERM_BYTE;
              end else begin
                state      <= DONE;
                tx_data    <= 8'd0;
                tx_valid   <= 1'b0;
                sent_pulse <= 1'b1;
              end
            end else begin
              idx     <= idx + 1'b1;
              tx_data <= shreg[WW-1 -: 8];
              shreg   <= shreg << 8;
            end
          end
        end
        TERM: begin
          if (handshake) begin
            state      <= DONE;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            sent_pulse <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          sent_pulse <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          tx_data    <= 8'd0;
          tx_valid   <= 1'b0;
          busy       <= 1'b0;
          sent_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dh_status_tx.sv
// Bench for dh_status_tx: a terminated and an unterminated instance share stimulus and are
// checked every cycle against a queue-based message model, plus literal directed expectations.
module tb_dh_status_tx;

  localparam logic [47:0] ACCEPT = 48'h414343455054;

  logic        clk;
  logic        rst;
  logic [47:0] status_in;
  logic        tx_ready;
  logic [7:0]  tx_data_a, tx_data_b, drop_cnt_a, drop_cnt_b;
  logic        tx_valid_a, tx_valid_b, busy_a, busy_b, sent_pulse_a, sent_pulse_b;

  int n_vec;
  int n_miss;

  dh_status_tx #(.WORD_BYTES(6), .TERM_EN(1'b1), .TERM_BYTE(8'h0A)) u_a (
    .clk(clk), .rst(rst), .status_in(status_in), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .busy(busy_a), .sent_pulse(sent_pulse_a), .drop_cnt(drop_cnt_a)
  );

  dh_status_tx #(.WORD_BYTES(6), .TERM_EN(1'b0), .TERM_BYTE(8'h0A)) u_b (
    .clk(clk), .rst(rst), .status_in(status_in), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .busy(busy_b), .sent_pulse(sent_pulse_b), .drop_cnt(drop_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a message is a queue of outstanding bytes; the head is what must be on the bus.
  logic [7:0] mq[2][$];
  bit         mpulse[2];
  int         mdrop[2];
  bit         mprev_zero;

  initial begin
    mprev_zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mpulse[i] = 1'b0;
      mdrop[i]  = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          mq[i].delete();
          mpulse[i] = 1'b0;
          mdrop[i]  = 0;
        end
        mprev_zero = 1'b1;
      end else begin
        bit trig;
        trig = mprev_zero && (status_in != 48'd0);
        for (int i = 0; i < 2; i++) begin
          if (trig && (mq[i].size() != 0 || mpulse[i]) && mdrop[i] < 255) mdrop[i]++;
          if (mq[i].size() != 0) begin
            if (tx_ready) begin
              void'(mq[i].pop_front());
              if (mq[i].size() == 0) mpulse[i] = 1'b1;
            end
          end else if (mpulse[i]) begin
            mpulse[i] = 1'b0;
          end else if (trig) begin
            for (int k = 0; k < 6; k++) mq[i].push_back(status_in[47-8*k -: 8]);
            if (i == 0) mq[i].push_back(8'h0A);
          end
        end
        mprev_zero = (status_in == 48'd0);
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("a_valid", tx_valid_a, mq[0].size() != 0);
      chk("a_data",  tx_data_a,  (mq[0].size() != 0) ? mq[0][0] : 0);
      chk("a_busy",  busy_a,     (mq[0].size() != 0) || mpulse[0]);
      chk("a_pulse", sent_pulse_a, mpulse[0]);
      chk("a_drop",  drop_cnt_a, mdrop[0]);
      chk("b_valid", tx_valid_b, mq[1].size() != 0);
      chk("b_data",  tx_data_b,  (mq[1].size() != 0) ? mq[1][0] : 0);
      chk("b_busy",  busy_b,     (mq[1].size() != 0) || mpulse[1]);
      chk("b_pulse", sent_pulse_b, mpulse[1]);
      chk("b_drop",  drop_cnt_b, mdrop[1]);
    end
  end

  // Handshake log and pulse counters used by the directed checks.
  logic [7:0] log_a[$];
  logic [7:0] log_b[$];
  int pulses_a, pulses_b;
  initial begin
    pulses_a = 0;
    pulses_b = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tx_valid_a && tx_ready) log_a.push_back(tx_data_a);
        if (tx_valid_b && tx_ready) log_b.push_back(tx_data_b);
        if (sent_pulse_a) pulses_a++;
        if (sent_pulse_b) pulses_b++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int budget, output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (ca == 0 && sent_pulse_a) ca = c;
      if (cb == 0 && sent_pulse_b) cb = c;
      if (ca != 0 && cb != 0) break;
    end
    if (ca == 0) chk("pulse_a_timeout", 0, 1);
    if (cb == 0) chk("pulse_b_timeout", 0, 1);
  endtask

  task automatic chk_msg(input string name, input int sa, input int sb);
    logic [7:0] exp_bytes [7];
    exp_bytes = '{8'h41, 8'h43, 8'h43, 8'h45, 8'h50, 8'h54, 8'h0A};
    chk({name, "_len_a"}, log_a.size() - sa, 7);
    chk({name, "_len_b"}, log_b.size() - sb, 6);
    for (int k = 0; k < 7; k++)
      if (sa + k < log_a.size()) chk({name, "_byte_a"}, log_a[sa+k], exp_bytes[k]);
    for (int k = 0; k < 6; k++)
      if (sb + k < log_b.size()) chk({name, "_byte_b"}, log_b[sb+k], exp_bytes[k]);
  endtask

  initial begin
    int sa, sb, ca, cb, pa, pb, budget;
    logic [47:0] w;
    n_vec = 0;
    n_miss = 0;
    rst = 1'b0;
    status_in = 48'd0;
    tx_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", tx_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_drop", drop_cnt_a, 0);
    rst = 1'b1;
    repeat (3) step();

    // Full message with ready held high: pulse 9 negedges after the word appears (8 unterminated).
    sa = log_a.size(); sb = log_b.size();
    status_in = ACCEPT;
    wait_pulses(40, ca, cb);
    chk("lat_pulse_a", ca, 9);
    chk("lat_pulse_b", cb, 8);
    step();
    chk_msg("basic", sa, sb);
    chk("basic_drop", drop_cnt_a, 0);
    status_in = 48'd0;
    repeat (4) step();

    // Backpressure with ready pattern 1,0,0,1 repeating.
    sa = log_a.size(); sb = log_b.size();
    status_in = ACCEPT;
    budget = 0;
    while (!(sent_pulse_a && !busy_b) && budget < 80) begin
      tx_ready = (budget % 4 == 0) || (budget % 4 == 3);
      step();
      budget++;
    end
    chk("bp_budget", budget < 80, 1);
    tx_ready = 1'b1;
    repeat (3) step();
    chk_msg("bp", sa, sb);
    status_in = 48'd0;
    repeat (3) step();

    // Three retriggers during a stalled message are dropped, not queued.
    sa = log_a.size(); sb = log_b.size();
    pa = pulses_a; pb = pulses_b;
    tx_ready = 1'b0;
    status_in = ACCEPT;
    repeat (2) step();
    repeat (3) begin
      status_in = 48'd0;
      step();
      status_in = ACCEPT;
      step();
    end
    tx_ready = 1'b1;
    wait_pulses(40, ca, cb);
    repeat (20) step();
    chk_msg("drop3", sa, sb);
    chk("drop3_cnt_a", drop_cnt_a, 3);
    chk("drop3_cnt_b", drop_cnt_b, 3);
    chk("drop3_pulses_a", pulses_a - pa, 1);
    chk("drop3_pulses_b", pulses_b - pb, 1);

    // Steady nonzero word for 100 cycles produces nothing.
    sa = log_a.size();
    repeat (100) step();
    chk("hold_bytes", log_a.size() - sa, 0);
    chk("hold_busy", busy_a, 0);

    // Reset while 0x45 is on the bus, then a fresh message after release.
    status_in = 48'd0;
    step();
    status_in = ACCEPT;
    budget = 0;
    while (tx_data_a != 8'h45 && budget < 20) begin
      step();
      budget++;
    end
    chk("rst_mid_found", tx_data_a, 8'h45);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", tx_valid_a, 0);
    chk("rst_mid_busy", busy_a, 0);
    chk("rst_mid_data", tx_data_a, 0);
    repeat (3) step();
    sa = log_a.size(); sb = log_b.size();
    rst = 1'b1;
    wait_pulses(40, ca, cb);
    step();
    chk_msg("rst_resend", sa, sb);

    // 260 dropped triggers saturate the counter at 255.
    status_in = 48'd0;
    step();
    sa = log_a.size(); sb = log_b.size();
    tx_ready = 1'b0;
    status_in = ACCEPT;
    step();
    repeat (260) begin
      status_in = 48'd0;
      step();
      status_in = ACCEPT;
      step();
    end
    tx_ready = 1'b1;
    wait_pulses(40, ca, cb);
    step();
    chk_msg("sat", sa, sb);
    chk("sat_cnt_a", drop_cnt_a, 255);
    chk("sat_cnt_b", drop_cnt_b, 255);

    // Randomized traffic checked by the per-cycle model compare.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 6) status_in = 48'd0;
      else if (r == 7) status_in = ACCEPT;
      else if (r == 8) status_in = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      else if (r == 9) begin
        w = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
        w[31:16] = 16'h0000;
        status_in = w;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      step();
      rst = 1'b1;
    end
    tx_ready = 1'b1;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
